// File: rtl/axi_lite_selftest_master_if.sv
// rtl/axi_lite_selftest_master_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi_lite_selftest_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_selftest_master.sv
// rtl/axi_lite_selftest_master.sv - AXI4-Lite write/readback/compare self-test master (watchdog: AXI_SELFTEST_TIMEOUT_EN)
module axi_lite_selftest_master #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
    parameter int                            ADDR_STRIDE        = 4,
    parameter logic [31:0]                   SEED               = 32'h0101FFFF,
    parameter logic [31:0]                   PAT_STEP           = 32'h0101_0101
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            start,
    input  logic                            mode,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [7:0]                      err_count,
    output logic [7:0]                      first_err_idx,
    output logic                            timeout,
    axi_lite_selftest_master_if.master      m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    localparam logic [DW-1:0] SEED_X   = DW'(SEED);
    localparam logic [DW-1:0] STEP_X   = DW'(PAT_STEP);
    localparam logic [AW-1:0] STRIDE_X = AW'(ADDR_STRIDE);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     idx_q, idx_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic           bulk_q, bulk_d;
    logic           aw_done_q, aw_done_d;
    logic           w_done_q, w_done_d;
    logic [7:0]     err_count_q, err_count_d;
    logic [7:0]     first_err_idx_q, first_err_idx_d;
    logic           err_seen_q, err_seen_d;
    logic           pass_q, pass_d;
    logic           timeout_q, timeout_d;

    logic           aw_hs, w_hs, aw_ok, w_ok, last, log_err;

`ifdef AXI_SELFTEST_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CYCLES = 16'd1024;
    logic [15:0]    wdog_q, wdog_d;
    logic           waiting;
`endif

    assign last  = (idx_q == LAST_IDX);
    assign aw_hs = (state_q == S_WR) && !aw_done_q && m_axi.awready;
    assign w_hs  = (state_q == S_WR) && !w_done_q && m_axi.wready;

    // Next-state, pattern/address stepping and error bookkeeping
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        addr_d          = addr_q;
        data_d          = data_q;
        bulk_d          = bulk_q;
        aw_done_d       = aw_done_q;
        w_done_d        = w_done_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        err_seen_d      = err_seen_q;
        pass_d          = pass_q;
        timeout_d       = timeout_q;
        log_err         = 1'b0;
        aw_ok           = aw_done_q | aw_hs;
        w_ok            = w_done_q | w_hs;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d         = S_WR;
                    idx_d           = 8'd0;
                    addr_d          = BASE_ADDR;
                    data_d          = SEED_X;
                    bulk_d          = mode;
                    aw_done_d       = 1'b0;
                    w_done_d        = 1'b0;
                    err_count_d     = 8'd0;
                    first_err_idx_d = 8'd0;
                    err_seen_d      = 1'b0;
                    pass_d          = 1'b0;
                    timeout_d       = 1'b0;
                end
            end
            S_WR: begin
                aw_done_d = aw_ok;
                w_done_d  = w_ok;
                if (aw_ok && w_ok) begin
                    state_d   = S_WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_WR_B: begin
                if (m_axi.bvalid) begin
                    log_err = (m_axi.bresp != 2'b00);
                    if (!bulk_q) begin
                        state_d = S_RD_AR;
                    end else if (last) begin
                        // Write phase finished: rewind to register 0 for readback
                        state_d = S_RD_AR;
                        idx_d   = 8'd0;
                        addr_d  = BASE_ADDR;
                        data_d  = SEED_X;
                    end else begin
                        state_d = S_WR;
                        idx_d   = idx_q + 8'd1;
                        addr_d  = addr_q + STRIDE_X;
                        data_d  = data_q + STEP_X;
                    end
                end
            end
            S_RD_AR: begin
                if (m_axi.arready) begin
                    state_d = S_RD_R;
                end
            end
            S_RD_R: begin
                if (m_axi.rvalid) begin
                    // A bad response and a data mismatch on one read count once
                    log_err = (m_axi.rresp != 2'b00) || (m_axi.rdata != data_q);
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = bulk_q ? S_RD_AR : S_WR;
                        idx_d   = idx_q + 8'd1;
                        addr_d  = addr_q + STRIDE_X;
                        data_d  = data_q + STEP_X;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (log_err) begin
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
            if (!err_seen_q) begin
                err_seen_d      = 1'b1;
                first_err_idx_d = idx_q;
            end
        end

`ifdef AXI_SELFTEST_TIMEOUT_EN
        waiting = (state_q == S_WR) || (state_q == S_WR_B) ||
                  (state_q == S_RD_AR) || (state_q == S_RD_R);
        wdog_d  = (!waiting || (state_d != state_q)) ? 16'd0 : wdog_q + 16'd1;
        if (waiting && (state_d == state_q) && (wdog_q == TIMEOUT_CYCLES - 16'd1)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            wdog_d    = 16'd0;
        end
`endif

        if ((state_q != S_DONE) && (state_d == S_DONE)) begin
            pass_d = (err_count_d == 8'd0) && !timeout_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q         <= S_IDLE;
            idx_q           <= 8'd0;
            addr_q          <= '0;
            data_q          <= '0;
            bulk_q          <= 1'b0;
            aw_done_q       <= 1'b0;
            w_done_q        <= 1'b0;
            err_count_q     <= 8'd0;
            first_err_idx_q <= 8'd0;
            err_seen_q      <= 1'b0;
            pass_q          <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            bulk_q          <= bulk_d;
            aw_done_q       <= aw_done_d;
            w_done_q        <= w_done_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            err_seen_q      <= err_seen_d;
            pass_q          <= pass_d;
            timeout_q       <= timeout_d;
        end
    end

`ifdef AXI_SELFTEST_TIMEOUT_EN
    // Watchdog counter, cleared whenever the FSM moves
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = (state_q == S_WR) && !aw_done_q;
    assign m_axi.wdata   = data_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = (state_q == S_WR) && !w_done_q;
    assign m_axi.bready  = (state_q == S_WR_B);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = (state_q == S_RD_AR);
    assign m_axi.rready  = (state_q == S_RD_R);

    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign timeout       = timeout_q;
endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// tb/tb_axi_lite_selftest_master.sv - directed scoreboard bench for axi_lite_selftest_master
module tb_axi_lite_selftest_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0, mode = 1'b0;
    logic       busy, done, pass, timeout;
    logic [7:0] err_count, first_err_idx;
    logic       start256 = 1'b0;
    logic       busy256, done256, pass256, timeout256;
    logic [7:0] err256, first256;

    axi_lite_selftest_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();
    axi_lite_selftest_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi256 ();

    axi_lite_selftest_master #(.NUM_REGS(4)) u_dut (
        .ACLK(clk), .ARESET(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx),
        .timeout(timeout), .m_axi(axi)
    );

    axi_lite_selftest_master #(.NUM_REGS(256)) u_dut256 (
        .ACLK(clk), .ARESET(rst), .start(start256), .mode(1'b0), .busy(busy256), .done(done256),
        .pass(pass256), .err_count(err256), .first_err_idx(first256),
        .timeout(timeout256), .m_axi(axi256)
    );

    // Slave controls
    bit stall_en = 0, ar_block = 0, clr_log = 0;
    int corrupt_idx = -1, slverr_idx = -1;

    // Main memory-backed slave with optional stalls and fault injection, plus bus monitor
    int aw_cnt, w_cnt, ar_cnt, b_gap, r_gap;
    logic aw_got, w_got, ar_got;
    logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
    logic [31:0] mem [0:15];
    logic [31:0] wr_log_addr[$], wr_log_data[$];
    int aw_hs_n, wr_before_ar, viol;
    bit ar_seen, aw_pend, w_pend, ar_pend;
    logic aw_hs, w_hs, ar_hs, aw_have, w_have, ar_have;
    logic [31:0] a_use, d_use, r_use;

    assign axi.awready = (aw_cnt == 0);
    assign axi.wready  = (w_cnt == 0);
    assign axi.arready = (ar_cnt == 0) && !ar_block;

    function int rnd_stall();
        return stall_en ? int'($urandom_range(0, 5)) : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_gap <= 0; r_gap <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= '0;
            aw_pend <= 0; w_pend <= 0; ar_pend <= 0;
        end else begin
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            ar_hs = axi.arvalid && axi.arready;
            if (clr_log) begin
                wr_log_addr.delete(); wr_log_data.delete();
                aw_hs_n <= 0; wr_before_ar <= -1; ar_seen <= 0; viol <= 0;
            end else begin
                if (aw_pend && !axi.awvalid && !timeout) viol <= viol + 1;
                if (w_pend && !axi.wvalid && !timeout) viol <= viol + 1;
                if (ar_pend && !axi.arvalid && !timeout) viol <= viol + 1;
                if (aw_hs) aw_hs_n <= aw_hs_n + 1;
                if (ar_hs && !ar_seen) begin
                    ar_seen <= 1; wr_before_ar <= aw_hs_n;
                end
            end
            aw_pend <= axi.awvalid && !axi.awready;
            w_pend  <= axi.wvalid && !axi.wready;
            ar_pend <= axi.arvalid && !axi.arready;

            if (aw_hs) aw_cnt <= rnd_stall(); else if (aw_cnt != 0) aw_cnt <= aw_cnt - 1;
            if (w_hs) w_cnt <= rnd_stall(); else if (w_cnt != 0) w_cnt <= w_cnt - 1;
            if (ar_hs) ar_cnt <= rnd_stall(); else if (ar_cnt != 0) ar_cnt <= ar_cnt - 1;

            if (axi.bvalid && axi.bready) begin
                axi.bvalid <= 1'b0; b_gap <= rnd_stall();
            end else if (b_gap != 0) b_gap <= b_gap - 1;
            if (axi.rvalid && axi.rready) begin
                axi.rvalid <= 1'b0; r_gap <= rnd_stall();
            end else if (r_gap != 0) r_gap <= r_gap - 1;

            aw_have = aw_got || aw_hs;
            w_have  = w_got || w_hs;
            a_use   = aw_got ? aw_addr_s : axi.awaddr;
            d_use   = w_got ? w_data_s : axi.wdata;
            if (aw_have && w_have && !axi.bvalid && b_gap == 0) begin
                mem[a_use[5:2]] <= d_use;
                axi.bresp  <= (int'(a_use[9:2]) == slverr_idx) ? 2'b10 : 2'b00;
                axi.bvalid <= 1'b1;
                aw_got <= 1'b0; w_got <= 1'b0;
                if (!clr_log) begin
                    wr_log_addr.push_back(a_use); wr_log_data.push_back(d_use);
                end
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= axi.awaddr; end
                if (w_hs) begin w_got <= 1'b1; w_data_s <= axi.wdata; end
            end

            ar_have = ar_got || ar_hs;
            r_use   = ar_got ? ar_addr_s : axi.araddr;
            if (ar_have && !axi.rvalid && r_gap == 0) begin
                axi.rdata  <= mem[r_use[5:2]] ^ ((int'(r_use[9:2]) == corrupt_idx) ? 32'h1 : 32'h0);
                axi.rresp  <= 2'b00;
                axi.rvalid <= 1'b1;
                ar_got <= 1'b0;
            end else if (ar_hs) begin
                ar_got <= 1'b1; ar_addr_s <= axi.araddr;
            end
        end
    end

    // Zero-wait slave for the 256-register instance; every readback is corrupted
    logic [31:0] mem256 [0:255];
    assign axi256.awready = 1'b1;
    assign axi256.wready  = 1'b1;
    assign axi256.arready = 1'b1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            axi256.bvalid <= 1'b0; axi256.bresp <= 2'b00;
            axi256.rvalid <= 1'b0; axi256.rresp <= 2'b00; axi256.rdata <= '0;
        end else begin
            if (axi256.bvalid && axi256.bready) axi256.bvalid <= 1'b0;
            if (axi256.rvalid && axi256.rready) axi256.rvalid <= 1'b0;
            if (axi256.awvalid && axi256.wvalid) begin
                mem256[axi256.awaddr[9:2]] <= axi256.wdata;
                axi256.bvalid <= 1'b1;
            end
            if (axi256.arvalid) begin
                axi256.rdata  <= mem256[axi256.araddr[9:2]] ^ 32'h1;
                axi256.rvalid <= 1'b1;
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic       p;
        logic [7:0] e;
        logic [7:0] f;
    } res_t;
    res_t        exp_res[$];
    logic [31:0] exp_addr[$], exp_data[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        clr_log = 1; tick(1); clr_log = 0;
    endtask

    task automatic push_run(input logic p, input logic [7:0] e, input logic [7:0] f);
        res_t r;
        logic [31:0] d;
        r.p = p; r.e = e; r.f = f;
        exp_res.push_back(r);
        d = 32'h0101FFFF;
        for (int k = 0; k < 4; k++) begin
            exp_addr.push_back(32'(k * 4));
            exp_data.push_back(d);
            d = d + 32'h0101_0101;
        end
    endtask

    task automatic pulse_start(input logic m);
        mode = m; start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin tick(1); n++; end
        check({tag, "_done_reached"}, done, 1'b1);
    endtask

    task automatic compare_run(input string tag);
        res_t r;
        int nw;
        r = exp_res.pop_front();
        check({tag, "_pass"}, pass, r.p);
        check({tag, "_err_count"}, err_count, r.e);
        check({tag, "_first_err_idx"}, first_err_idx, r.f);
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        nw = wr_log_addr.size();
        check({tag, "_num_writes"}, nw, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < nw) begin
                check($sformatf("%s_waddr%0d", tag, k), wr_log_addr[k], exp_addr[0]);
                check($sformatf("%s_wdata%0d", tag, k), wr_log_data[k], exp_data[0]);
            end
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
        end
    endtask

    initial begin
        int n;
        // Reset state
        rst = 1'b1;
        tick(3);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err_count", err_count, 8'd0);
        check("rst_first_err_idx", first_err_idx, 8'd0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
        rst = 1'b0;
        tick(2);

        // Interleaved, zero-wait: exact latency
        clear_log();
        push_run(1'b1, 8'd0, 8'd0);
        pulse_start(1'b0);
        check("a_busy_n1", busy, 1'b1);
        check("a_awvalid_n1", {axi.awvalid, axi.wvalid}, 2'b11);
        tick(15);
        check("a_done_n16", done, 1'b0);
        tick(1);
        check("a_done_n17", done, 1'b1);
        compare_run("a");

        // Bulk with random stalls, started from DONE
        stall_en = 1;
        clear_log();
        push_run(1'b1, 8'd0, 8'd0);
        pulse_start(1'b1);
        check("b_cleared_done", done, 1'b0);
        wait_done("b", 1000);
        compare_run("b");
        check("b_writes_before_ar", wr_before_ar, 4);
        check("b_valid_drops", viol, 0);
        stall_en = 0;

        // Read corruption on register 2, SLVERR on register 3 write; extra start ignored
        corrupt_idx = 2; slverr_idx = 3;
        clear_log();
        push_run(1'b0, 8'd2, 8'd2);
        pulse_start(1'b0);
        tick(3);
        start = 1'b1; tick(1); start = 1'b0;
        check("c_busy_after_extra_start", busy, 1'b1);
        wait_done("c", 200);
        compare_run("c");
        corrupt_idx = -1; slverr_idx = -1;

        // Reset during WR_B of register 1, then a clean rerun
        clear_log();
        pulse_start(1'b0);
        tick(5);
        check("d_in_wrb1", {axi.bready, axi.awaddr}, {1'b1, 32'h4});
        rst = 1'b1;
        #1;
        check("d_rst_status", {busy, done, pass, timeout, err_count, first_err_idx}, 20'h0);
        check("d_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
        tick(3);
        rst = 1'b0;
        tick(1);
        clear_log();
        push_run(1'b1, 8'd0, 8'd0);
        pulse_start(1'b0);
        wait_done("d", 200);
        compare_run("d");

        // 256 registers, all readbacks wrong: saturation
        start256 = 1'b1; tick(1); start256 = 1'b0;
        n = 0;
        while (!done256 && n < 3000) begin tick(1); n++; end
        check("e_done_reached", done256, 1'b1);
        check("e_err_sat", err256, 8'd255);
        check("e_first_err_idx", first256, 8'd0);
        check("e_pass", pass256, 1'b0);

`ifdef AXI_SELFTEST_TIMEOUT_EN
        // Watchdog on a stuck read address channel
        ar_block = 1;
        clear_log();
        pulse_start(1'b0);
        n = 0;
        while (!axi.arvalid && n < 50) begin tick(1); n++; end
        check("f_arvalid_seen", axi.arvalid, 1'b1);
        n = 0;
        while (!timeout && n < 2000) begin tick(1); n++; end
        check("f_timeout_cycles", n, 1024);
        check("f_flags", {timeout, done, pass, axi.arvalid}, 4'b1100);
        ar_block = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
